// File: rtl/goldschmidt_ctrl.sv
// rtl/goldschmidt_ctrl.sv - Goldschmidt divider sequencer driving the mux/k-register/multiplier datapath
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-low reset
//   start             divide request, accepted only while busy=0
//   n_in/d_in/ia_in   numerator, normalised denominator, initial reciprocal (Q1.15)
//   dp_result         registered datapath product (Q2.30)
//   dp_n/dp_d/dp_ia   running numerator, running denominator, latched IA to datapath
//   dp_kSelect        0: k from IA, 1: k generated from previous product
//   dp_ndSelect       0: multiply N and load k register, 1: multiply D and hold k
//   busy, done        busy from accept through DONE; done pulses while q_out is valid
//   q_out             quotient, held until the next done
module goldschmidt_ctrl #(
    parameter int WIDTH = 16,
    parameter int ITER  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   n_in,
    input  logic [WIDTH-1:0]   d_in,
    input  logic [WIDTH-1:0]   ia_in,
    input  logic [2*WIDTH-1:0] dp_result,
    output logic [WIDTH-1:0]   dp_n,
    output logic [WIDTH-1:0]   dp_d,
    output logic [WIDTH-1:0]   dp_ia,
    output logic               dp_kSelect,
    output logic               dp_ndSelect,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   q_out
);

    localparam int ITW = $clog2(ITER) + 1;
    localparam logic [ITW-1:0] IT_LAST = ITW'(ITER - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOADK,
        S_MULD,
        S_MULN,
        S_CAPN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [ITW-1:0]   it_q, it_d;
    logic [WIDTH-1:0] n_q, n_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] ia_q, ia_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] prod16;
    logic             unused_lsbs;

    // Q2.30 -> Q1.15 by truncation; anything >= 2.0 clamps to all ones.
    assign prod16 = dp_result[2*WIDTH-1] ? {WIDTH{1'b1}} : dp_result[2*WIDTH-2:WIDTH-1];
    assign unused_lsbs = ^dp_result[WIDTH-2:0];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            it_q    <= '0;
            n_q     <= '0;
            d_q     <= '0;
            ia_q    <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            it_q    <= it_d;
            n_q     <= n_d;
            d_q     <= d_d;
            ia_q    <= ia_d;
            q_q     <= q_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        it_d        = it_q;
        n_d         = n_q;
        d_d         = d_q;
        ia_d        = ia_q;
        q_d         = q_q;
        busy        = 1'b1;
        done        = 1'b0;
        dp_kSelect  = 1'b0;
        dp_ndSelect = 1'b1;
        unique case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    n_d     = n_in;
                    d_d     = d_in;
                    ia_d    = ia_in;
                    it_d    = '0;
                    state_d = S_LOADK;
                end
            end
            S_LOADK: begin
                dp_ndSelect = 1'b0;
                state_d     = S_MULD;
            end
            S_MULD: begin
                dp_kSelect = 1'b1;
                state_d    = S_MULN;
            end
            S_MULN: begin
                // dp_result holds d*k from MULD; the datapath derives the next k from it too.
                dp_kSelect  = 1'b1;
                dp_ndSelect = 1'b0;
                d_d         = prod16;
                state_d     = S_CAPN;
            end
            S_CAPN: begin
                // dp_result holds n*k from MULN, computed with the k before this update.
                dp_kSelect = 1'b1;
                n_d        = prod16;
                if (it_q == IT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    it_d    = it_q + ITW'(1);
                    state_d = S_MULD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                q_d     = n_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign dp_n  = n_q;
    assign dp_d  = d_q;
    assign dp_ia = ia_q;
    // Bypass the final numerator during DONE so q_out is already valid with the done pulse.
    assign q_out = (state_q == S_DONE) ? n_q : q_q;

endmodule

// File: doc/goldschmidt_ctrl.md
Name: goldschmidt_ctrl

Overview:
Sequencer for the Goldschmidt divider datapath (mux + k-register + CSA multiplier + registered 32-bit product). It accepts a divide request with a start/done handshake and latches the operands. It then drives the datapath's kSelect/ndSelect controls for ITER iterations and folds each registered product back into its running numerator/denominator registers. It presents the final quotient. It sits between the FPU issue logic and the datapath.

Parameters:
WIDTH, 16, operand/quotient width; unsigned Q1.15, 0x8000 = 1.0
ITER, 4, Goldschmidt iterations per divide (1..15)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  request; accepted only when busy=0
n_in  input  WIDTH  numerator, Q1.15
d_in  input  WIDTH  denominator, Q1.15, normalised to [0.5,1.0]
ia_in  input  WIDTH  initial reciprocal approximation, Q1.15
dp_result  input  2*WIDTH  registered datapath product, Q2.30
dp_n  output  WIDTH  numerator operand to datapath (n_reg)
dp_d  output  WIDTH  denominator operand to datapath (d_reg)
dp_ia  output  WIDTH  latched IA to datapath
dp_kSelect  output  1  0 = k from IA, 1 = k generated from previous product
dp_ndSelect  output  1  0 = multiply N and load k register, 1 = multiply D and hold k
busy  output  1  high from accept until the cycle after done
done  output  1  one-cycle pulse when q_out is valid
q_out  output  WIDTH  quotient; holds its value until the next done

Behaviour:
- Reset (asserted asynchronously while reset=0): state=IDLE, it=0, all registers 0, busy=0, done=0, q_out=0, dp_kSelect=0, dp_ndSelect=1.
- Product slice: prod16 = dp_result[30:15]. Truncate, no rounding. A product of 2.0 or more (dp_result[31]=1) saturates to 0xFFFF.
- States and per-state outputs:
  - IDLE:
    - outputs: ndSelect=1, kSelect=0, busy=0.
    - on start: n_reg<=n_in, d_reg<=d_in, ia_reg<=ia_in, it<=0, go to LOADK.
  - LOADK:
    - outputs: ndSelect=0, kSelect=0, busy=1. The k register loads IA.
    - go to MULD.
  - MULD:
    - outputs: ndSelect=1, kSelect=1. The datapath computes d_reg*k.
    - go to MULN.
  - MULN:
    - outputs: ndSelect=0, kSelect=1. The datapath computes n_reg*k, and the k register loads k generated from dp_result (= d_reg*k).
    - d_reg<=prod16(dp_result).
    - go to CAPN.
  - CAPN:
    - outputs: ndSelect=1, kSelect=1. k is held.
    - n_reg<=prod16(dp_result).
    - if it==ITER-1: go to DONE; else it<=it+1 and go to MULD.
  - DONE:
    - outputs: busy=1, ndSelect=1.
    - q_out<=n_reg and done=1 for exactly this cycle.
    - go to IDLE.
- Latency: done asserts 3*ITER+2 cycles after the accepting edge (ITER=4 gives 14).
- start while busy=1: ignored, with no effect on state or registers.
- start in the IDLE cycle immediately after DONE: accepted normally (back-to-back divides allowed).
- Reset mid-operation: abort immediately to the reset values above. No done is issued, and q_out clears to 0.
- it counter width = clog2(ITER)+1. Wrap-around is not possible because the DONE exit is compared against ITER-1.
- dp_n/dp_d/dp_ia are direct register outputs, stable for the whole operation except at the MULN/CAPN update edges.
- Inputs n_in/d_in/ia_in are sampled only on the accepting edge. Later changes have no effect.

Test Plan:
- Identity: N=0x6000, D=0x8000, IA=0x8000, ITER=4 -> k stays 1.0 every iteration; done at cycle 14 after accept; q_out=0x6000.
- Real divide: N=0x6000 (0.75), D=0x4000 (0.5), IA=0xFFFF -> q_out within 2 LSB of 0xC000 (1.5); d_reg converges to within 2 LSB of 0x8000.
- Control trace: monitor (kSelect,ndSelect) per cycle -> exact sequence (0,0),(1,1),(1,0),(1,1) repeated ITER times for the last three, then DONE with ndSelect=1; busy high throughout.
- Handshake: pulse start again at cycle 5 of a divide with different operands -> ignored and result unchanged; start held during DONE/IDLE -> second divide begins the cycle after DONE and produces a correct q_out.
- Reset abort: assert reset=0 at cycle 7 of a divide -> same cycle: busy=0, q_out=0, state IDLE; no done pulse after release.
- Saturation: force dp_result=0x8000_0000 during CAPN -> n_reg=0xFFFF.
